// File: rtl/apb3_slave_mem.sv
// ---------------------------------------------------------------------------
// apb3_slave_mem
//   APB3 completer that backs a MEM_DEPTH-word memory. Each transfer gets a
//   programmable number of wait states, sampled from wait_cfg during the setup
//   phase and clamped to MAX_WAIT. Addresses outside 0..MEM_DEPTH-1 complete
//   with PSLVERR=1, leave the memory unchanged and return PRDATA=0.
//
// Ports
//   PCLK      in   clock, all logic on posedge
//   PRESET    in   synchronous reset, active-high (also clears the memory)
//   PSELx     in   slave select
//   PENABLE   in   access phase
//   PWRITE    in   1=write, 0=read
//   PADDR     in   word address (ADDR_WIDTH)
//   PWDATA    in   write data (DATA_WIDTH)
//   wait_cfg  in   wait states for the transfer being set up
//   PREADY    out  transfer completes when high in access phase (registered)
//   PRDATA    out  read data, valid while PREADY=1 (registered)
//   PSLVERR   out  error flag, valid while PREADY=1 (registered)
// ---------------------------------------------------------------------------
module apb3_slave_mem #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 256,
    parameter int MAX_WAIT   = 4
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  PSELx,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [3:0]            wait_cfg,
    output logic                  PREADY,
    output logic [DATA_WIDTH-1:0] PRDATA,
    output logic                  PSLVERR
);

    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(MEM_DEPTH);
    localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [IDX_W-1:0]      addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  write_q, write_d;
    logic                  err_q, err_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  pready_q, pready_d;
    logic                  pslverr_q, pslverr_d;
    logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

    logic       setup_s;
    logic       access_s;
    logic [3:0] wait_clamp_s;
    logic       commit_s;

    assign setup_s      = PSELx & ~PENABLE;
    assign access_s     = PSELx & PENABLE;
    assign wait_clamp_s = (wait_cfg > MAX_W) ? MAX_W : wait_cfg;
    // In DONE PREADY is always 1, so an access cycle there is the completing edge.
    assign commit_s     = (state_q == ST_DONE) && access_s && write_q && !err_q;

    // State register.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. PENABLE=1 in IDLE is not a setup and is ignored.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (setup_s) begin
                    state_d = (wait_clamp_s == 4'd0) ? ST_DONE : ST_WAIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (!PSELx) begin
                    state_d = ST_IDLE;
                end else if (PENABLE && (cnt_q == 4'd1)) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_DONE: begin
                if (!PSELx || PENABLE) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Transfer context: latched at setup so later master changes cannot retarget it.
    always_comb begin
        addr_d  = addr_q;
        wdata_d = wdata_q;
        write_d = write_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (setup_s) begin
                    addr_d  = PADDR[IDX_W-1:0];
                    wdata_d = PWDATA;
                    write_d = PWRITE;
                    err_d   = (PADDR >= DEPTH_A);
                    cnt_d   = wait_clamp_s;
                end else begin
                    cnt_d   = cnt_q;
                end
            end
            ST_WAIT: begin
                if (access_s) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    cnt_d = cnt_q;
                end
            end
            default: cnt_d = cnt_q;
        endcase
    end

    // Output logic: loaded on the edge that enters DONE, cleared on any exit.
    always_comb begin
        pready_d  = (state_d == ST_DONE);
        pslverr_d = 1'b0;
        prdata_d  = '0;
        if (pready_d) begin
            pslverr_d = err_d;
            // Read of the memory happens here, after any earlier write committed.
            prdata_d  = (!err_d && !write_d) ? mem_q[addr_d] : '0;
        end else begin
            pslverr_d = 1'b0;
            prdata_d  = '0;
        end
    end

    // Transfer context and registered outputs.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            addr_q    <= '0;
            wdata_q   <= '0;
            write_q   <= 1'b0;
            err_q     <= 1'b0;
            cnt_q     <= 4'd0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
        end else begin
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            write_q   <= write_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            prdata_q  <= prdata_d;
        end
    end

    // Memory array; reset clears every word and drops any pending write.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (commit_s) begin
            mem_q[addr_q] <= wdata_q;
        end
    end

    assign PREADY  = pready_q;
    assign PSLVERR = pslverr_q;
    assign PRDATA  = prdata_q;

endmodule
